// File: rtl/countdown_timer_if.sv
// Control and display bundle of the MM:SS countdown timer.
interface countdown_timer_if;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] state;
    logic       expired;
    logic       done;

    modport master (
        output load, load_min, load_sec, start, pause, tick,
        input  min, sec, state, expired, done
    );

    modport slave (
        input  load, load_min, load_sec, start, pause, tick,
        output min, sec, state, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD minutes:seconds down-counter with load clamping, pause/resume
// and a single-cycle expiry pulse on reaching 00:00.
module countdown_timer #(
    parameter int MAX_MIN_TENS = 9
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [3:0] MIN_TENS_LIM = 4'(MAX_MIN_TENS);

    state_t     cur, nxt;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       exp_q, exp_d;
    logic [7:0] min_dec, sec_dec;
    logic [7:0] min_ld, sec_ld;
    logic       is_zero, is_one;

    function automatic logic [3:0] clamp(input logic [3:0] v,
                                         input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign min_ld  = {clamp(bus.load_min[7:4], MIN_TENS_LIM),
                      clamp(bus.load_min[3:0], 4'd9)};
    assign sec_ld  = {clamp(bus.load_sec[7:4], 4'd5),
                      clamp(bus.load_sec[3:0], 4'd9)};
    assign is_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign is_one  = (min_q == 8'h00) && (sec_q == 8'h01);

    // One-second BCD decrement with seconds borrowing from minutes
    always_comb begin
        min_dec = min_q;
        sec_dec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            sec_dec = {sec_q[7:4], sec_q[3:0] - 4'd1};
        end else if (sec_q[7:4] != 4'd0) begin
            sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
        end else if (min_q != 8'h00) begin
            sec_dec = 8'h59;
            if (min_q[3:0] != 4'd0)
                min_dec = {min_q[7:4], min_q[3:0] - 4'd1};
            else
                min_dec = {min_q[7:4] - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur   <= IDLE;
            min_q <= 8'h00;
            sec_q <= 8'h00;
            exp_q <= 1'b0;
        end else begin
            cur   <= nxt;
            min_q <= min_d;
            sec_q <= sec_d;
            exp_q <= exp_d;
        end
    end

    always_comb begin
        nxt   = cur;
        min_d = min_q;
        sec_d = sec_q;
        exp_d = 1'b0;
        if (bus.load) begin
            nxt   = IDLE;
            min_d = min_ld;
            sec_d = sec_ld;
        end else begin
            unique case (cur)
                IDLE: begin
                    if (bus.start && !bus.pause) begin
                        nxt   = is_zero ? DONE : RUN;
                        exp_d = is_zero;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        nxt = PAUSED;
                    end else if (bus.tick && !is_zero) begin
                        min_d = min_dec;
                        sec_d = sec_dec;
                        if (is_one) begin
                            nxt   = DONE;
                            exp_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start && !bus.pause)
                        nxt = RUN;
                end
                DONE: begin
                    nxt = DONE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.min     = min_q;
        bus.sec     = sec_q;
        bus.state   = cur;
        bus.expired = exp_q;
        bus.done    = (cur == DONE);
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus
// reset and full-minute countdown sequences.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic reset = 1'b0;

    countdown_timer_if bus();

    countdown_timer #(.MAX_MIN_TENS(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] lm;
        logic [7:0] ls;
        logic       st;
        logic       pa;
        logic       tk;
        logic [7:0] em;
        logic [7:0] es;
        logic [1:0] est;
        logic       eexp;
    } vec_t;

    vec_t vecs[$];
    int passed = 0;
    int total = 0;
    int pulses = 0;

    function automatic vec_t mk(
        input logic ld, input logic [7:0] lm, input logic [7:0] ls,
        input logic st, input logic pa, input logic tk,
        input logic [7:0] em, input logic [7:0] es,
        input logic [1:0] est, input logic eexp);
        vec_t v;
        v.ld = ld; v.lm = lm; v.ls = ls;
        v.st = st; v.pa = pa; v.tk = tk;
        v.em = em; v.es = es; v.est = est; v.eexp = eexp;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [7:0] em,
                         input logic [7:0] es, input logic [1:0] est,
                         input logic eexp);
        logic [19:0] got;
        logic [19:0] want;
        got  = {bus.min, bus.sec, bus.state, bus.expired, bus.done};
        want = {em, es, est, eexp, (est == 2'b11)};
        total++;
        if (got === want)
            passed++;
        else
            $display("FAIL %s: got %h:%h st=%b exp=%b done=%b, want %h:%h st=%b exp=%b done=%b",
                     name, bus.min, bus.sec, bus.state, bus.expired,
                     bus.done, em, es, est, eexp, (est == 2'b11));
    endtask

    task automatic drive(input logic ld, input logic [7:0] lm,
                         input logic [7:0] ls, input logic st,
                         input logic pa, input logic tk);
        @(negedge clk);
        bus.load = ld; bus.load_min = lm; bus.load_sec = ls;
        bus.start = st; bus.pause = pa; bus.tick = tk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.load = 0; bus.load_min = 0; bus.load_sec = 0;
        bus.start = 0; bus.pause = 0; bus.tick = 0;

        // ld lm ls st pa tk -> min sec state expired
        vecs.push_back(mk(1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h59, 2'b01, 0));
        vecs.push_back(mk(1, 8'hA7, 8'h7C, 0, 0, 0, 8'h97, 8'h59, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 8'h97, 8'h59, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 1, 8'h97, 8'h59, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h97, 8'h58, 2'b01, 0));
        vecs.push_back(mk(1, 8'h02, 8'h00, 0, 0, 0, 8'h02, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h02, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 8'h59, 2'b01, 0));
        vecs.push_back(mk(1, 8'h00, 8'h10, 1, 0, 0, 8'h00, 8'h10, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h10, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h09, 2'b01, 0));
        vecs.push_back(mk(1, 8'h00, 8'h30, 0, 0, 0, 8'h00, 8'h30, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h30, 2'b10, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h30, 2'b10, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 8'h30, 2'b10, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h30, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h29, 2'b01, 0));
        vecs.push_back(mk(1, 8'h05, 8'h00, 0, 0, 0, 8'h05, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h00, 2'b01, 0));
        vecs.push_back(mk(1, 8'h03, 8'h20, 1, 0, 1, 8'h03, 8'h20, 2'b00, 0));
        vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 2'b11, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 1, 8'h00, 8'h00, 2'b11, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h00, 2'b11, 0));
        vecs.push_back(mk(1, 8'h00, 8'h01, 0, 0, 0, 8'h00, 8'h01, 2'b00, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h01, 2'b01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 2'b11, 1));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 2'b11, 0));
        vecs.push_back(mk(1, 8'h00, 8'h05, 0, 0, 0, 8'h00, 8'h05, 2'b00, 0));

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("reset", 8'h00, 8'h00, 2'b00, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lm, vecs[i].ls,
                  vecs[i].st, vecs[i].pa, vecs[i].tk);
            check($sformatf("vec%0d", i), vecs[i].em, vecs[i].es,
                  vecs[i].est, vecs[i].eexp);
        end

        // Reset held low for two cycles in the middle of a run
        drive(1, 8'h12, 8'h34, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("run_12_33", 8'h12, 8'h33, 2'b01, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        check("mid_reset", 8'h00, 8'h00, 2'b00, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("post_reset_tick", 8'h00, 8'h00, 2'b00, 0);

        // Full minute down to expiry against an integer-seconds model
        drive(1, 8'h01, 8'h00, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("min_start", 8'h01, 8'h00, 2'b01, 0);
        for (int k = 1; k <= 60; k++) begin
            int t;
            t = 60 - k;
            drive(0, 0, 0, 0, 0, 1);
            if (bus.expired) pulses++;
            check($sformatf("count_%0d", t), 8'h00, to_bcd(t),
                  (t == 0) ? 2'b11 : 2'b01, (t == 0));
        end
        drive(0, 0, 0, 0, 0, 1);
        if (bus.expired) pulses++;
        check("after_done", 8'h00, 8'h00, 2'b11, 0);
        total++;
        if (pulses == 1)
            passed++;
        else
            $display("FAIL pulse_count: got %0d, want 1", pulses);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
